fir_out_quantizer: RTL and testbench

Downstream stage of the fully parallel 8-tap FIR. Takes the 33-bit signed filter output and produces a 16-bit signed result:
- round-half-up, arithmetic right shift, then saturate;
- optional decimation by DECIM;
- buffering in a small FIFO behind a valid/ready output interface.

It keeps sticky saturation and overflow status for the system controller.

---
 rtl/fir_out_quantizer.sv | 187 ++++++++++++++++++
 tb/tb_fir_out_quantizer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_quantizer.sv
// ---------------------------------------------------------------------------
// fir_out_quantizer
// Output stage of the parallel 8-tap FIR. It rounds the wide signed filter
// result (round-half-up), shifts it right arithmetically and saturates it to
// OUT_WIDTH. It can keep only 1 of every DECIM samples, and it queues the
// results in a small FIFO behind a valid/ready interface. Sticky saturation
// and overflow flags are provided for the system controller.
//
// Optional feature macro: QUANT_SAT_CNT_EN. When it is defined, the block
// adds the sat_count output, a 16-bit saturating count of saturated samples.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      asynchronous active-high reset
//   in_valid   data_in carries a new filter sample this cycle
//   data_in    signed filter output, IN_WIDTH bits
//   out_valid  the FIFO head is valid
//   out_ready  the consumer takes the head this cycle
//   data_out   signed quantized sample at the FIFO head, OUT_WIDTH bits
//   sat_flag   sticky: at least one kept sample saturated
//   ovf_flag   sticky: at least one kept sample was dropped on a full FIFO
//   clr_flags  synchronous clear of both sticky flags (a set event wins)
//   fifo_level current FIFO occupancy
//   sat_count  (QUANT_SAT_CNT_EN only) number of saturated kept samples
// ---------------------------------------------------------------------------
module fir_out_quantizer #(
    parameter int IN_WIDTH   = 33,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic signed [IN_WIDTH-1:0]    data_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   data_out,
    output logic                          sat_flag,
    output logic                          ovf_flag,
    input  logic                          clr_flags,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef QUANT_SAT_CNT_EN
    ,
    output logic [15:0]                   sat_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    // This constant is half of one output LSB at the input scale.
    localparam logic signed [IN_WIDTH:0] RND = (IN_WIDTH + 1)'(1) << (SHIFT - 1);
    // These are the output limits, sign-extended to the internal width.
    localparam logic signed [IN_WIDTH:0] SAT_MAX =
        {{(IN_WIDTH + 1 - OUT_WIDTH){1'b0}}, 1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] SAT_MIN =
        {{(IN_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    // State
    logic [CW-1:0]                 dec_cnt_q, dec_cnt_d;
    logic                          s1_valid_q, s1_valid_d;
    logic signed [OUT_WIDTH-1:0]   s1_data_q, s1_data_d;
    logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [AW:0]                   level_q, level_d;
    logic                          sat_q, sat_d;
    logic                          ovf_q, ovf_d;
    logic signed [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];

    // Combinational datapath
    logic signed [IN_WIDTH:0]      rounded;
    logic signed [IN_WIDTH:0]      shifted;
    logic signed [OUT_WIDTH-1:0]   quant;
    logic                          sat_now;
    logic                          keep;
    logic                          push;
    logic                          pop;

    always_comb begin
        // The extra sign bit keeps the rounding add from overflowing.
        rounded = $signed({data_in[IN_WIDTH-1], data_in}) + RND;
        shifted = rounded >>> SHIFT;
        sat_now = 1'b0;
        quant   = shifted[OUT_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            quant   = SAT_MAX[OUT_WIDTH-1:0];
            sat_now = 1'b1;
        end else if (shifted < SAT_MIN) begin
            quant   = SAT_MIN[OUT_WIDTH-1:0];
            sat_now = 1'b1;
        end
    end

    always_comb begin
        keep      = in_valid && (dec_cnt_q == '0);
        dec_cnt_d = dec_cnt_q;
        if (in_valid) begin
            dec_cnt_d = (dec_cnt_q == CW'(DECIM - 1)) ? '0 : dec_cnt_q + 1'b1;
        end

        s1_valid_d = keep;
        s1_data_d  = keep ? quant : s1_data_q;

        // A full FIFO still accepts the stage-1 sample if the head leaves
        // on the same edge.
        pop  = (level_q != '0) && out_ready;
        push = s1_valid_q && ((level_q != (AW + 1)'(FIFO_DEPTH)) || pop);

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        // A set event wins over a clear in the same cycle.
        sat_d = (sat_q && !clr_flags) || (keep && sat_now);
        ovf_d = (ovf_q && !clr_flags) || (s1_valid_q && !push);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            dec_cnt_q  <= dec_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage needs no reset; the entries are only visible through a
    // nonzero level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s1_data_q;
        end
    end

    assign out_valid  = (level_q != '0);
    assign data_out   = out_valid ? mem[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign sat_flag   = sat_q;
    assign ovf_flag   = ovf_q;

`ifdef QUANT_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic        sat_inc;

    always_comb begin
        sat_inc = keep && sat_now;
        if (clr_flags) begin
            sat_cnt_d = sat_inc ? 16'd1 : 16'd0;
        end else if (sat_inc && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_out_quantizer.sv
// ---------------------------------------------------------------------------
// Testbench for fir_out_quantizer.
// u0 uses the default parameters (DECIM=1, FIFO_DEPTH=4).
// u1 uses DECIM=2, and its consumer is always ready.
// ---------------------------------------------------------------------------
module tb_fir_out_quantizer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               iv = 1'b0;
    logic               iv2 = 1'b0;
    logic               rdy = 1'b0;
    logic               clr = 1'b0;
    logic signed [32:0] din = '0;

    logic               ov, sat, ovf;
    logic signed [15:0] dout;
    logic [2:0]         lvl;
    logic               ov2, sat2, ovf2;
    logic signed [15:0] dout2;
    logic [2:0]         lvl2;
`ifdef QUANT_SAT_CNT_EN
    logic [15:0]        cnt0, cnt1;
`endif

    fir_out_quantizer #(.DECIM(1)) u0 (
        .clk(clk), .reset(rst), .in_valid(iv), .data_in(din),
        .out_valid(ov), .out_ready(rdy), .data_out(dout),
        .sat_flag(sat), .ovf_flag(ovf), .clr_flags(clr), .fifo_level(lvl)
`ifdef QUANT_SAT_CNT_EN
        , .sat_count(cnt0)
`endif
    );

    fir_out_quantizer #(.DECIM(2)) u1 (
        .clk(clk), .reset(rst), .in_valid(iv2), .data_in(din),
        .out_valid(ov2), .out_ready(1'b1), .data_out(dout2),
        .sat_flag(sat2), .ovf_flag(ovf2), .clr_flags(1'b0), .fifo_level(lvl2)
`ifdef QUANT_SAT_CNT_EN
        , .sat_count(cnt1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference quantizer: floor((v + 2^14) / 2^15), then clamp to 16 bits.
    function automatic longint qref(input longint v);
        longint r;
        r = (v + 64'sd16384) >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic bit sref(input longint v);
        longint r;
        r = (v + 64'sd16384) >>> 15;
        return (r > 32767) || (r < -32768);
    endfunction

    // Samples seen at the output of u1 (its consumer is always ready).
    longint cap[$];
    always @(negedge clk) if (ov2) cap.push_back(longint'(dout2));

    typedef struct {
        longint din;
        longint dout;
        bit     sat;
    } vec_t;
    vec_t vecs[9];

    // Cycle-level model of u0, used for the random phase.
    longint mq[$];
    bit     m_s1v;
    longint m_s1d;
    bit     m_sat, m_ovf;

    task automatic model_edge();
        bit     pop, push, satset;
        longint v;
        v      = longint'(din);
        pop    = (mq.size() > 0) && rdy;
        push   = m_s1v && ((mq.size() < 4) || pop);
        satset = iv && sref(v);
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(m_s1d);
        m_ovf = (m_ovf && !clr) || (m_s1v && !push);
        m_sat = (m_sat && !clr) || satset;
        m_s1v = iv;
        m_s1d = qref(v);
    endtask

    initial begin
        vecs[0] = '{16383, 0, 0};
        vecs[1] = '{16384, 1, 0};
        vecs[2] = '{-16384, 0, 0};
        vecs[3] = '{49152, 2, 0};
        vecs[4] = '{-16385, -1, 0};
        vecs[5] = '{64'sd32767 * 32768, 32767, 0};
        vecs[6] = '{64'sd2147483647, 32767, 1};
        vecs[7] = '{-64'sd4294967296, -32768, 1};
        vecs[8] = '{-64'sd32768 * 32768 - 16384, -32768, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", ov, 0);
        chk("rst_level", lvl, 0);
        chk("rst_data_out", dout, 0);
        chk("rst_sat", sat, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        step();

        // Table-driven rounding and saturation
        rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            din = 33'(vecs[i].din);
            iv  = 1'b1;
            step();
            iv = 1'b0;
            step();
            $display("vec %0d: din=%0d data_out=%0d sat=%0b", i, vecs[i].din, dout, sat);
            chk("tbl_valid", ov, 1);
            chk("tbl_data", dout, vecs[i].dout);
            chk("tbl_sat", sat, vecs[i].sat);
            chk("tbl_ovf", ovf, 0);
            step();
            chk("tbl_popped", ov, 0);
            if (vecs[i].sat) begin
                clr = 1'b1;
                step();
                clr = 1'b0;
                chk("tbl_sat_clr", sat, 0);
            end
        end

        // Decimation by 2 on u1
        cap.delete();
        for (int k = 1; k <= 6; k++) begin
            din = 33'(k * 32768);
            iv2 = 1'b1;
            step();
        end
        iv2 = 1'b0;
        repeat (4) step();
        chk("dec_count", cap.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("dec_data", (cap.size() > i) ? cap[i] : -99999, 2 * i + 1);
        end
        $display("decim: %0d samples kept", cap.size());

        // Overflow: 6 samples into a 4-deep FIFO with the consumer stalled
        rdy = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            din = 33'(k * 32768);
            iv  = 1'b1;
            step();
        end
        iv = 1'b0;
        step();
        step();
        chk("ovf_level", lvl, 4);
        chk("ovf_flag", ovf, 1);
        step();
        chk("ovf_hold", dout, 1);
        rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_drain_valid", ov, 1);
            chk("ovf_drain_data", dout, k);
            $display("drain: data_out=%0d", dout);
            step();
        end
        chk("ovf_empty", ov, 0);
        rdy = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("ovf_clr", ovf, 0);

        // Full FIFO with a pop on the same edge as the write
        for (int k = 1; k <= 4; k++) begin
            din = 33'(k * 32768);
            iv  = 1'b1;
            step();
        end
        iv = 1'b0;
        step();
        step();
        chk("full_level", lvl, 4);
        din = 33'(9 * 32768);
        iv  = 1'b1;
        step();
        iv  = 1'b0;
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("full_pop_level", lvl, 4);
        chk("full_pop_ovf", ovf, 0);
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("full_pop_data", dout, (i == 3) ? 9 : i + 2);
            step();
        end
        rdy = 1'b0;

        // Reset mid-operation: 3 entries queued and one sample in stage 1
        din = 33'sd2147483647;
        iv  = 1'b1;
        step();
        for (int k = 2; k <= 4; k++) begin
            din = 33'(k * 32768);
            step();
        end
        iv = 1'b0;
        chk("mid_pre_level", lvl, 3);
        chk("mid_pre_sat", sat, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", ov, 0);
        chk("mid_rst_level", lvl, 0);
        chk("mid_rst_sat", sat, 0);
        chk("mid_rst_ovf", ovf, 0);
        step();
        rst = 1'b0;
        step();
        chk("mid_s1_discarded", ov, 0);
        rdy = 1'b1;
        din = 33'(5 * 32768);
        iv  = 1'b1;
        step();
        iv = 1'b0;
        chk("mid_latency_early", ov, 0);
        step();
        chk("mid_latency_valid", ov, 1);
        chk("mid_latency_data", dout, 5);
        step();

        // Random stimulus checked against the model
        rst = 1'b1;
        step();
        rst = 1'b0;
        mq.delete();
        m_s1v = 0; m_s1d = 0; m_sat = 0; m_ovf = 0;
        for (int c = 0; c < 600; c++) begin
            chk("rnd_valid", ov, mq.size() > 0);
            chk("rnd_level", lvl, mq.size());
            if (mq.size() > 0) chk("rnd_data", dout, mq[0]);
            chk("rnd_sat", sat, m_sat);
            chk("rnd_ovf", ovf, m_ovf);
            begin
                bit [63:0] r64;
                longint    v;
                r64 = {$urandom(), $urandom()};
                case ($urandom_range(0, 2))
                    0: v = longint'($urandom_range(0, 2097152)) - 1048576;
                    1: v = ($urandom_range(0, 1) ? 1 : -1) *
                           (64'sd1073725440 + longint'($urandom_range(0, 65535)));
                    default: v = longint'($signed(r64[32:0]));
                endcase
                din = 33'(v);
            end
            iv  = ($urandom_range(0, 3) != 0);
            rdy = (c % 80 < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
        iv  = 1'b0;
        clr = 1'b0;
        $display("random phase done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
